adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parameterised N-bit unsigned/two's-complement adder with carry-in, carry-out and signed-overflow flag.
- Registered and optionally pipelined: the carry chain is split into STAGES segments, one register stage per segment.
- Full throughput of one operation per clock, with a valid bit travelling alongside the data.
- Used as the datapath arithmetic primitive wherever a timing-closed N-bit add is needed.

Parameters:
- N, 4, operand and sum width in bits (N >= 1).
- STAGES, 1, number of pipeline register stages, equal to the latency in cycles (1 <= STAGES <= N).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  qualifies a, b and cin in this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in, added at bit 0.
- out_valid  output  1  sum, cout and ovf hold a completed result.
- sum  output  N  low N bits of a+b+cin.
- cout  output  1  carry out of bit N-1; the unsigned result is {cout,sum}.
- ovf  output  1  signed overflow: a[N-1]==b[N-1] and sum[N-1]!=a[N-1].

Behaviour:
- Arithmetic: {cout,sum} = a + b + cin, exact, modulo 2^(N+1). No saturation.
- ovf is computed from the operand sign bits and the final sum sign bit.
- Segmentation:
  - Width W = ceil(N/STAGES). Segment k covers bits [k*W, min((k+1)*W, N)-1].
  - Segment 0 adds at stage 0 using cin.
  - Segment k adds at stage k using the registered carry out of stage k-1.
  - Operand bits not yet consumed and sum bits already produced are carried forward in the pipeline registers.
  - With STAGES > N/W, trailing stages may be empty pass-through stages; latency is still exactly STAGES.
- Latency: result for inputs sampled at rising edge t appears on outputs after edge t+STAGES-1. With STAGES=1, outputs are valid in the cycle after the sampling edge.
- Throughput: new inputs are accepted every cycle. There is no stall or backpressure.
- Valid: in_valid shifts through a STAGES-deep valid pipe, and out_valid is its last bit.
- Data registers load every cycle regardless of in_valid. Output data with out_valid=0 is don't-care for consumers.
- Reset:
  - rst=1 at a rising edge clears every pipeline register, so out_valid=0, sum=0, cout=0, ovf=0 after that edge.
  - Reset mid-operation discards all in-flight results; no out_valid pulse for them.
  - in_valid sampled in the same cycle as rst=1 is ignored.
- After reset release, the first in_valid produces out_valid exactly STAGES cycles later.
- No combinational path from inputs to outputs.
- Boundaries:
  - All-ones + 1 wraps: sum=0, cout=1.
  - All-ones + all-ones + cin=1: sum all-ones, cout=1.
  - N=1 and STAGES=N must elaborate and work.

Test Plan:
- N=4, STAGES=1: a=0001, b=0001, cin=0, in_valid=1 -> one cycle later out_valid=1, {cout,sum}=0_0010, ovf=0.
- N=4, STAGES=1: a=1111, b=0001, cin=0 -> {cout,sum}=1_0000, ovf=0.
- N=4: a=0111, b=0000, cin=1 -> sum=1000, cout=0, ovf=1.
- N=4: a=1000, b=1000 -> sum=0000, cout=1, ovf=1.
- N=4, STAGES=2, back-to-back inputs (1+1, 15+1, 7+8, 15+15+cin) on consecutive cycles:
  - Results 2, 16, 15 and 31 appear in order, two cycles after each input.
  - out_valid is high for 4 consecutive cycles.
- STAGES=2: assert rst for one cycle while two operations are in flight -> out_valid stays 0, outputs 0 from the next edge, and no stale result emerges afterwards.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: N-bit adder with carry-in, carry-out and signed-overflow flag.
// The carry chain is cut into STAGES segments of W = ceil(N/STAGES) bits,
// one register stage per segment; latency is exactly STAGES cycles and a
// new operation is accepted every cycle. Trailing stages whose segment lies
// beyond bit N-1 simply pass their inputs through.
module adder_pipe #(
   parameter int unsigned N      = 4,
   parameter int unsigned STAGES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int unsigned W = (N + STAGES - 1) / STAGES;
   localparam int unsigned L = STAGES - 1;

   // Per-stage pipeline registers: operands, partial sum, running carry, valid.
   logic [STAGES-1:0][N-1:0] a_q, a_d;
   logic [STAGES-1:0][N-1:0] b_q, b_d;
   logic [STAGES-1:0][N-1:0] s_q, s_d;
   logic [STAGES-1:0]        c_q, c_d;
   logic [STAGES-1:0]        v_q, v_d;

   // Each stage ripples its own segment using the carry registered by the previous stage.
   always_comb begin
      logic [N-1:0] a_in, b_in, s_in;
      logic         c_in, v_in, c;
      int unsigned  p;
      a_in = '0;
      b_in = '0;
      s_in = '0;
      c_in = 1'b0;
      v_in = 1'b0;
      c    = 1'b0;
      p    = 0;
      a_d  = '0;
      b_d  = '0;
      s_d  = '0;
      c_d  = '0;
      v_d  = '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         p = (s == 0) ? 0 : s - 1;
         if (s == 0) begin
            a_in = a;
            b_in = b;
            s_in = '0;
            c_in = cin;
            v_in = in_valid;
         end else begin
            a_in = a_q[p];
            b_in = b_q[p];
            s_in = s_q[p];
            c_in = c_q[p];
            v_in = v_q[p];
         end
         c = c_in;
         for (int unsigned i = 0; i < N; i++) begin
            if (i >= s * W && i < (s + 1) * W) begin
               s_in[i] = a_in[i] ^ b_in[i] ^ c;
               c       = (a_in[i] & b_in[i]) | (c & (a_in[i] ^ b_in[i]));
            end
         end
         a_d[s] = a_in;
         b_d[s] = b_in;
         s_d[s] = s_in;
         c_d[s] = c;
         v_d[s] = v_in;
      end
   end

   // Pipeline registers load every cycle; synchronous reset flushes all stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         c_q <= '0;
         v_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign out_valid = v_q[L];
   assign sum       = s_q[L];
   assign cout      = c_q[L];
   // Overflow derived from registered operand signs and final sum sign only.
   assign ovf       = (a_q[L][N-1] == b_q[L][N-1]) && (s_q[L][N-1] != a_q[L][N-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboard bench driving four adder_pipe instances
// (N=4 with STAGES=1,2,3 and N=1 with STAGES=1) from one directed vector table.
module tb_adder_pipe;

   typedef struct {
      logic [3:0]  s;
      logic        c;
      logic        o;
      int unsigned cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a_in;
   logic [3:0] b_in;
   logic       cin;

   int unsigned cyc    = 0;
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Directed vectors: a, b, cin, hand-computed N=4 result and N=1 (bit 0) result.
   localparam int NV = 11;
   logic [3:0] va  [NV] = '{4'h1, 4'hF, 4'h7, 4'h8, 4'h7, 4'hF, 4'h5, 4'h0, 4'h9, 4'hC, 4'h3};
   logic [3:0] vb  [NV] = '{4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'hF, 4'h3, 4'h0, 4'h6, 4'hA, 4'h4};
   logic       vc  [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic [3:0] es  [NV] = '{4'h2, 4'h0, 4'h8, 4'h0, 4'hF, 4'hF, 4'h8, 4'h1, 4'h0, 4'h6, 4'h8};
   logic       ec  [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   logic       eo  [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       e1s [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic       e1c [NV] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic       e1o [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned NN = (g == 3) ? 1 : 4;
      localparam int unsigned SS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 1;

      logic          ov;
      logic [NN-1:0] s;
      logic          co;
      logic          of;
      exp_t          q[$];

      adder_pipe #(.N(NN), .STAGES(SS)) dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .a         (a_in[NN-1:0]),
         .b         (b_in[NN-1:0]),
         .cin       (cin),
         .out_valid (ov),
         .sum       (s),
         .cout      (co),
         .ovf       (of)
      );

      // Monitor: reset state, in-order results with exact latency, no stray or missing results.
      always @(posedge clk) begin
         exp_t          e;
         logic [NN-1:0] want_s;
         #1;
         if (rst) begin
            n_chk++;
            if (ov !== 1'b0 || s !== '0 || co !== 1'b0 || of !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_state[%0d] got v=%b s=%h c=%b o=%b want all zero", g, ov, s, co, of);
            end
         end else if (ov === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid[%0d] cyc=%0d got s=%h c=%b o=%b want no output", g, cyc, s, co, of);
            end else begin
               e      = q.pop_front();
               want_s = e.s[NN-1:0];
               if (s !== want_s || co !== e.c || of !== e.o || cyc != e.cyc + SS) begin
                  n_fail++;
                  $display("FAIL result[%0d] got s=%h c=%b o=%b cyc=%0d want s=%h c=%b o=%b cyc=%0d",
                           g, s, co, of, cyc, want_s, e.c, e.o, e.cyc + SS);
               end
            end
         end else if (ov !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_x[%0d] got out_valid=%b want 0/1", g, ov);
         end else if (q.size() > 0 && cyc > q[0].cyc + SS) begin
            n_chk++;
            n_fail++;
            e = q.pop_front();
            $display("FAIL missing_result[%0d] got no out_valid by cyc=%0d want at cyc=%0d", g, cyc, e.cyc + SS);
         end
      end
   end

   task automatic push_all(input int i);
      exp_t e4, e1;
      e4.s = es[i];  e4.c = ec[i];  e4.o = eo[i];  e4.cyc = cyc;
      e1.s = {3'b000, e1s[i]}; e1.c = e1c[i]; e1.o = e1o[i]; e1.cyc = cyc;
      g_dut[0].q.push_back(e4);
      g_dut[1].q.push_back(e4);
      g_dut[2].q.push_back(e4);
      g_dut[3].q.push_back(e1);
   endtask

   task automatic flush_all();
      g_dut[0].q.delete();
      g_dut[1].q.delete();
      g_dut[2].q.delete();
      g_dut[3].q.delete();
   endtask

   // Drive one cycle of stimulus at the falling edge; record expectation when it will be accepted.
   task automatic step(input logic v, input int i);
      @(negedge clk);
      in_valid = v;
      a_in     = va[i];
      b_in     = vb[i];
      cin      = vc[i];
      if (v && !rst) push_all(i);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 0);
   endtask

   task automatic check_drained(input int g, input int sz);
      n_chk++;
      if (sz != 0) begin
         n_fail++;
         $display("FAIL drain[%0d] got %0d pending results want 0", g, sz);
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
      cin      = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Isolated operations
      for (int i = 0; i < 4; i++) begin
         step(1'b1, i);
         idle(4);
      end

      // Back-to-back: 1+1, 15+1, 7+8, 15+15+1
      step(1'b1, 0);
      step(1'b1, 1);
      step(1'b1, 4);
      step(1'b1, 5);
      idle(5);

      // Remaining vectors, mixed with gaps
      step(1'b1, 6);
      step(1'b1, 7);
      idle(1);
      step(1'b1, 8);
      step(1'b1, 9);
      step(1'b1, 10);
      idle(5);

      // Reset with operations in flight; in_valid during reset is ignored
      step(1'b1, 2);
      step(1'b1, 3);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      a_in     = va[5];
      b_in     = vb[5];
      cin      = vc[5];
      flush_all();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      idle(5);

      // First operation after reset release
      step(1'b1, 6);
      step(1'b1, 9);
      idle(6);

      check_drained(0, g_dut[0].q.size());
      check_drained(1, g_dut[1].q.size());
      check_drained(2, g_dut[2].q.size());
      check_drained(3, g_dut[3].q.size());

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
